// File: rtl/alsu_arbiter.sv
// alsu_arbiter: shares one registered ALSU between two command requesters.
// Each transaction follows IDLE -> ISSUE -> WAIT -> RESP. The granted command is
// driven onto the ALSU pins for exactly the ISSUE cycle. The ALSU result is
// captured in WAIT and returned on a valid/ready response channel.
// Optional build macro ALSU_ARB_FIXED_PRIO_EN: when defined, requester 0 always
// wins a tie. When undefined (the default), ties are resolved round-robin.
module alsu_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [15:0] req_cmd0,
   input  logic [15:0] req_cmd1,
   output logic [1:0]  resp_valid,
   input  logic [1:0]  resp_ready,
   output logic [5:0]  resp_data,
   output logic        resp_err,
   output logic        grant_id,
   output logic        busy,
   output logic [2:0]  alsu_A,
   output logic [2:0]  alsu_B,
   output logic [2:0]  alsu_opcode,
   output logic        alsu_cin,
   output logic        alsu_serial_in,
   output logic        alsu_red_op_A,
   output logic        alsu_red_op_B,
   output logic        alsu_bypass_A,
   output logic        alsu_bypass_B,
   output logic        alsu_direction,
   input  logic [5:0]  alsu_out
);

   // Field layout of a requester command; all-zero is the parking command.
   typedef struct packed {
      logic [2:0] opcode;
      logic [2:0] a;
      logic [2:0] b;
      logic       cin;
      logic       serial_in;
      logic       red_op_a;
      logic       red_op_b;
      logic       bypass_a;
      logic       bypass_b;
      logic       direction;
   } alsu_cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t    state;
   alsu_cmd_t pins_q;
   alsu_cmd_t cmd_sel;
   logic      err_q;
   logic      gnt;
   logic      any_valid;
`ifndef ALSU_ARB_FIXED_PRIO_EN
   logic      last_grant;
`endif

   // Illegal only when neither operand is bypassed: reserved opcodes, or a
   // reduction request on an opcode that has no reduction form.
   function automatic logic illegal(input alsu_cmd_t c);
      if (c.bypass_a || c.bypass_b) return 1'b0;
      return (c.opcode[2:1] == 2'b11) ||
             ((c.red_op_a || c.red_op_b) && (c.opcode[2:1] != 2'b00));
   endfunction

   // Grant selection and combinational accept; only IDLE can accept.
   always_comb begin
      any_valid = |req_valid;
`ifdef ALSU_ARB_FIXED_PRIO_EN
      gnt = ~req_valid[0];
`else
      if (&req_valid) gnt = ~last_grant;
      else            gnt = req_valid[1];
`endif
      cmd_sel   = gnt ? alsu_cmd_t'(req_cmd1) : alsu_cmd_t'(req_cmd0);
      req_ready = 2'b00;
      if (state == IDLE && any_valid) req_ready[gnt] = 1'b1;
   end

   // Transaction FSM; every output except req_ready is registered here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
`ifndef ALSU_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
         pins_q     <= '0;
         err_q      <= 1'b0;
         grant_id   <= 1'b0;
         busy       <= 1'b0;
         resp_valid <= 2'b00;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  pins_q     <= cmd_sel;
                  err_q      <= illegal(cmd_sel);
                  grant_id   <= gnt;
`ifndef ALSU_ARB_FIXED_PRIO_EN
                  last_grant <= gnt;
`endif
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               // Park so the ALSU sees the command for this one cycle only.
               pins_q <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               resp_data            <= alsu_out;
               resp_err             <= err_q;
               resp_valid[grant_id] <= 1'b1;
               state                <= RESP;
            end
            RESP: begin
               if (resp_ready[grant_id]) begin
                  resp_valid <= 2'b00;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alsu_opcode    = pins_q.opcode;
   assign alsu_A         = pins_q.a;
   assign alsu_B         = pins_q.b;
   assign alsu_cin       = pins_q.cin;
   assign alsu_serial_in = pins_q.serial_in;
   assign alsu_red_op_A  = pins_q.red_op_a;
   assign alsu_red_op_B  = pins_q.red_op_b;
   assign alsu_bypass_A  = pins_q.bypass_a;
   assign alsu_bypass_B  = pins_q.bypass_b;
   assign alsu_direction = pins_q.direction;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: contains a registered ALSU model and a response
// scoreboard fed with expected results as each command is driven.
`timescale 1ns/1ps
module tb_alsu_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [15:0] req_cmd0 = '0;
   logic [15:0] req_cmd1 = '0;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready = 2'b00;
   logic [5:0]  resp_data;
   logic        resp_err;
   logic        grant_id;
   logic        busy;
   logic [2:0]  alsu_A, alsu_B, alsu_opcode;
   logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
   logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
   logic [5:0]  alsu_out;

   int checks   = 0;
   int failures = 0;

   typedef struct packed { logic id; logic [5:0] data; logic err; } exp_t;
   typedef struct packed { logic id; logic [15:0] cmd; logic [5:0] data; logic err; } vec_t;
   exp_t sb[$];

   localparam logic [6:0] CIN = 7'b1000000, SIN = 7'b0100000, RA = 7'b0010000,
                          RB = 7'b0001000, BA = 7'b0000100, DIR = 7'b0000001;

   alsu_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .grant_id(grant_id), .busy(busy), .alsu_A(alsu_A), .alsu_B(alsu_B),
      .alsu_opcode(alsu_opcode), .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
      .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
      .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
      .alsu_direction(alsu_direction), .alsu_out(alsu_out)
   );

   always #5 clk = ~clk;

   // Registered ALSU model: bypass first, invalid gives 0, shifts act on out.
   always @(posedge clk) begin
      if (!rst) alsu_out <= '0;
      else if (alsu_bypass_A) alsu_out <= {3'b0, alsu_A};
      else if (alsu_bypass_B) alsu_out <= {3'b0, alsu_B};
      else if (alsu_opcode[2:1] == 2'b11 ||
               ((alsu_red_op_A || alsu_red_op_B) && alsu_opcode[2:1] != 2'b00))
         alsu_out <= '0;
      else begin
         case (alsu_opcode)
            3'b000: alsu_out <= alsu_red_op_A ? {5'b0, &alsu_A} :
                                alsu_red_op_B ? {5'b0, &alsu_B} : {3'b0, alsu_A & alsu_B};
            3'b001: alsu_out <= alsu_red_op_A ? {5'b0, ^alsu_A} :
                                alsu_red_op_B ? {5'b0, ^alsu_B} : {3'b0, alsu_A ^ alsu_B};
            3'b010: alsu_out <= {3'b0, alsu_A} + {3'b0, alsu_B} + {5'b0, alsu_cin};
            3'b011: alsu_out <= {3'b0, alsu_A} * {3'b0, alsu_B};
            3'b100: alsu_out <= alsu_direction ? {alsu_out[4:0], alsu_serial_in}
                                               : {alsu_serial_in, alsu_out[5:1]};
            3'b101: alsu_out <= alsu_direction ? {alsu_out[4:0], alsu_out[5]}
                                               : {alsu_out[0], alsu_out[5:1]};
            default: alsu_out <= '0;
         endcase
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [6:0] ctl);
      return {op, a, b, ctl};
   endfunction

   function automatic logic [15:0] pins();
      return {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A,
              alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Drive one command and wait (bounded) for its accept; returns at ISSUE.
   task automatic send(input logic id, input logic [15:0] cmd,
                       output logic [1:0] rr, output int lat);
      if (id == 1'b0) req_cmd0 = cmd; else req_cmd1 = cmd;
      req_valid[id] = 1'b1;
      #1;
      lat = 0;
      while (req_ready[id] !== 1'b1 && lat < 20) begin tick(); lat++; end
      rr = req_ready;
      tick();
      req_valid[id] = 1'b0;
   endtask

   // Wait (bounded) for a response, capture it, then handshake with rmask.
   task automatic collect(input logic [1:0] rmask, output logic [1:0] rv, output logic g,
                          output logic [5:0] d, output logic e, output int wc);
      wc = 0;
      while (resp_valid === 2'b00 && wc < 20) begin tick(); wc++; end
      rv = resp_valid; g = grant_id; d = resp_data; e = resp_err;
      resp_ready = rmask;
      tick();
      resp_ready = 2'b00;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({resp_valid, resp_data, resp_err, grant_id, busy, pins()} !== 27'd0) begin
         failures++;
         $display("FAIL reset_outputs: rv=%b data=%b err=%b gid=%b busy=%b pins=%h, all zero required",
                  resp_valid, resp_data, resp_err, grant_id, busy, pins());
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] rr, rv; logic g, e; logic [5:0] d; int n, wc;
      exp_t ex;
      logic ord [4];
`ifdef ALSU_ARB_FIXED_PRIO_EN
      ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      for (int k = 0; k < 4; k++) sb.push_back('{ord[k], ord[k] ? 6'd15 : 6'd1, 1'b0});
      req_cmd0  = mk(3'b000, 3'b101, 3'b011, 7'd0);
      req_cmd1  = mk(3'b010, 3'b111, 3'b111, CIN);
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (req_ready === 2'b00 && n < 20) begin tick(); n++; end
         rr = req_ready;
         tick();
         collect(2'b11, rv, g, d, e, wc);
         ex = sb.pop_front();
         checks++;
         if (rr !== (2'b01 << ex.id) || {rv, g, d, e} !== {2'b01 << ex.id, ex.id, ex.data, ex.err}) begin
            failures++;
            $display("FAIL rr_grant_%0d: ready=%b rv=%b gid=%b data=%b err=%b, required id=%b data=%b err=%b",
                     k, rr, rv, g, d, e, ex.id, ex.data, ex.err);
         end
      end
      req_valid = 2'b00;
      tick();
   endtask

   task automatic run_table(input string nm, input vec_t v[6]);
      logic [1:0] rr, rv; logic g, e; logic [5:0] d; int lat, wc;
      exp_t ex;
      for (int i = 0; i < 6; i++) begin
         sb.push_back('{v[i].id, v[i].data, v[i].err});
         send(v[i].id, v[i].cmd, rr, lat);
         checks++;
         if (rr !== (2'b01 << v[i].id) || pins() !== v[i].cmd) begin
            failures++;
            $display("FAIL %s_issue_%0d: ready=%b pins=%h, required ready=%b pins=%h",
                     nm, i, rr, pins(), 2'b01 << v[i].id, v[i].cmd);
         end
         collect(2'b01 << v[i].id, rv, g, d, e, wc);
         ex = sb.pop_front();
         checks++;
         if ({rv, g, d, e} !== {2'b01 << ex.id, ex.id, ex.data, ex.err}) begin
            failures++;
            $display("FAIL %s_resp_%0d: rv=%b gid=%b data=%b err=%b, required id=%b data=%b err=%b",
                     nm, i, rv, g, d, e, ex.id, ex.data, ex.err);
         end
         checks++;
         if (wc !== 2) begin
            failures++;
            $display("FAIL %s_latency_%0d: resp after %0d cycles from ISSUE, required 2", nm, i, wc);
         end
      end
   endtask

   task automatic test_alu_ops();
      vec_t v[6];
      v[0] = '{1'b0, mk(3'b000, 3'b101, 3'b011, 7'd0), 6'b000001, 1'b0};
      v[1] = '{1'b1, mk(3'b010, 3'b111, 3'b111, CIN),  6'b001111, 1'b0};
      v[2] = '{1'b1, mk(3'b011, 3'b111, 3'b111, 7'd0), 6'b110001, 1'b0};
      v[3] = '{1'b0, mk(3'b100, 3'b000, 3'b000, SIN | DIR), 6'b000001, 1'b0};
      v[4] = '{1'b1, mk(3'b101, 3'b101, 3'b000, DIR), 6'b000000, 1'b0};
      v[5] = '{1'b0, mk(3'b001, 3'b110, 3'b011, 7'd0), 6'b000101, 1'b0};
      run_table("alu", v);
   endtask

   task automatic test_illegal();
      vec_t v[6];
      v[0] = '{1'b0, mk(3'b110, 3'b101, 3'b011, 7'd0), 6'b000000, 1'b1};
      v[1] = '{1'b1, mk(3'b010, 3'b011, 3'b010, RA),   6'b000000, 1'b1};
      v[2] = '{1'b0, mk(3'b110, 3'b101, 3'b000, BA),   6'b000101, 1'b0};
      v[3] = '{1'b1, mk(3'b111, 3'b001, 3'b001, 7'd0), 6'b000000, 1'b1};
      v[4] = '{1'b0, mk(3'b001, 3'b011, 3'b000, RB),   6'b000000, 1'b0};
      v[5] = '{1'b1, mk(3'b000, 3'b111, 3'b111, RA),   6'b000001, 1'b0};
      run_table("illegal", v);
   endtask

   task automatic test_back_pressure();
      logic [1:0] rr, rv; logic g, e; logic [5:0] d; int lat, wc;
      exp_t ex;
      sb.push_back('{1'b0, 6'd3, 1'b0});
      send(1'b0, mk(3'b010, 3'b001, 3'b010, 7'd0), rr, lat);
      tick(); tick();
      req_cmd1 = mk(3'b011, 3'b010, 3'b011, 7'd0);
      sb.push_back('{1'b1, 6'd6, 1'b0});
      req_valid[1] = 1'b1;
      resp_ready   = 2'b10;   // non-granted ready must be ignored
      ex = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({resp_valid, resp_data, resp_err, req_ready, busy, pins()} !==
             {2'b01, ex.data, ex.err, 2'b00, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL stall_%0d: rv=%b data=%b err=%b ready=%b busy=%b pins=%h, required rv=01 data=%b ready=00 busy=1",
                     c, resp_valid, resp_data, resp_err, req_ready, busy, pins(), ex.data);
         end
         tick();
      end
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b00;
      checks++;
      if ({busy, resp_valid, req_ready} !== 5'b0_00_10) begin
         failures++;
         $display("FAIL stall_release: busy=%b rv=%b ready=%b, required busy=0 rv=00 ready=10",
                  busy, resp_valid, req_ready);
      end
      tick();
      req_valid[1] = 1'b0;
      collect(2'b10, rv, g, d, e, wc);
      ex = sb.pop_front();
      checks++;
      if ({rv, g, d, e} !== {2'b10, 1'b1, ex.data, ex.err}) begin
         failures++;
         $display("FAIL stall_next: rv=%b gid=%b data=%b err=%b, required rv=10 gid=1 data=%b err=%b",
                  rv, g, d, e, ex.data, ex.err);
      end
   endtask

   task automatic test_reset_midflight();
      logic [1:0] rr, rv; logic g, e; logic [5:0] d; int lat, wc;
      exp_t ex;
      send(1'b0, mk(3'b011, 3'b011, 3'b011, 7'd0), rr, lat);   // now in ISSUE, no response expected
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, resp_valid, grant_id, pins()} !== 20'd0) begin
         failures++;
         $display("FAIL reset_issue: busy=%b rv=%b gid=%b pins=%h, all zero required",
                  busy, resp_valid, grant_id, pins());
      end
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         checks++;
         if ({busy, resp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_dropped_%0d: busy=%b rv=%b, required busy=0 rv=00", c, busy, resp_valid);
         end
      end
      req_cmd0 = mk(3'b000, 3'b111, 3'b110, 7'd0);
      req_cmd1 = mk(3'b010, 3'b001, 3'b001, 7'd0);
      sb.push_back('{1'b0, 6'd6, 1'b0});
      sb.push_back('{1'b1, 6'd2, 1'b0});
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL reset_first_grant: ready=%b, required 01", req_ready);
      end
      tick();
      req_valid[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin tick(); req_valid[1] = 1'b0; end
         collect(2'b11, rv, g, d, e, wc);
         ex = sb.pop_front();
         checks++;
         if ({rv, g, d, e} !== {2'b01 << ex.id, ex.id, ex.data, ex.err}) begin
            failures++;
            $display("FAIL reset_after_%0d: rv=%b gid=%b data=%b err=%b, required id=%b data=%b err=%b",
                     k, rv, g, d, e, ex.id, ex.data, ex.err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_alu_ops();
      test_illegal();
      test_back_pressure();
      test_reset_midflight();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alsu_arbiter.md
# alsu_arbiter

- Shares one ALSU instance between two command requesters.
- Grants one requester at a time (round-robin) and drives the granted 16-bit command onto the ALSU input pins for exactly one cycle.
- Captures the ALSU's registered 6-bit result and returns it, with an illegal-command flag, on a valid/ready response channel.
- Sits between the requester-side control logic and the ALSU; only this block drives the ALSU inputs.

## Interface
- Parameters: none. Requester count is fixed at 2.

Ports:
- clk  in  1  — the single clock.
- rst  in  1  — one clock; reset is synchronous and active-low.
- req_valid  in  2  — per-requester command valid.
- req_ready  out  2  — per-requester command accept; one-hot or zero.
- req_cmd0, req_cmd1  in  16 each  — command packed as {opcode[2:0], A[2:0], B[2:0], cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}.
- resp_valid  out  2  — response valid, routed to the granted requester only.
- resp_ready  in  2  — per-requester response accept.
- resp_data  out  6  — captured ALSU result.
- resp_err  out  1  — the command was illegal.
- grant_id  out  1  — requester owning the current transaction.
- busy  out  1  — high in every state other than IDLE.
- alsu_A, alsu_B, alsu_opcode  out  3 each  — ALSU operand and opcode pins.
- alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each  — ALSU control pins.
- alsu_out  in  6  — ALSU registered output.

## Operation
State machine: IDLE → ISSUE → WAIT → RESP → IDLE.

- **IDLE**
  - Choose grant g among the asserted req_valid bits.
  - req_ready[g] = 1 combinationally, only when req_valid[g] = 1.
  - On the edge: latch req_cmd_g, set grant_id = g, go to ISSUE.
- **ISSUE**
  - ALSU pins driven from the latched command for this one cycle.
- **WAIT**
  - ALSU pins return to the parking command.
  - On the edge: resp_data ← alsu_out; resp_err ← illegal(cmd).
- **RESP**
  - resp_valid[grant_id] held high with resp_data and resp_err stable until resp_ready[grant_id] = 1.
  - Then IDLE.
  - resp_ready of the non-granted requester is ignored.

Parking command (all states except ISSUE):
- Drives opcode 000, A = B = 0, and all control bits 0.
- The ALSU therefore outputs 0 one cycle later.
- Shift/rotate commands operate on out = 0: shift with direction = 1 returns {5'b0, serial_in}; rotate returns 0.

illegal(cmd), evaluated only when bypass_A = bypass_B = 0:
- opcode ∈ {110, 111}, or
- (red_op_A | red_op_B) with opcode ∉ {000, 001}.
- Illegal commands are still issued; the ALSU returns 0.

Arbitration:
- Round-robin pointer last_grant; reset value 1, so requester 0 wins first.
- Both valid → grant = ~last_grant. One valid → that requester.
- last_grant updates only on accept.

Requester rules:
- req_cmd_i must be stable while req_valid_i is high.
- req_valid_i must not drop before req_ready_i.
- Commands arriving outside IDLE wait; req_ready stays 0.

## Timing
Transaction timeline, where t is the IDLE accept cycle:
- t: req_ready pulses.
- t+1: ISSUE.
- t+2: WAIT.
- t+3: resp_valid at the earliest.
- Minimum of 4 cycles per transaction; the next accept is at earliest the cycle after the response handshake.

Outputs are registered except req_ready.

Reset values (rst = 0 at an edge):
- state = IDLE, last_grant = 1.
- All outputs 0, ALSU pins at parking.
- Any in-flight transaction is dropped with no response.
- Reset wins over any simultaneous handshake.

resp_valid with resp_ready low: response held indefinitely with no change.

## Configuration
- Macro: ALSU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid, and last_grant is unused.
- Undefined (default): round-robin as above.

## Test plan
- Reset release; req0 cmd opcode 000, A = 101, B = 011 → req_ready = 01 at t, resp_valid = 01 at t+3, resp_data = 000001, resp_err = 0.
- req1 ADD with A = 7, B = 7, cin = 1 → resp_data = 001111; then MUL with A = 7, B = 7 → resp_data = 110001.
- Both requesters valid continuously for 4 transactions → grant order 0, 1, 0, 1.
  - With ALSU_ARB_FIXED_PRIO_EN: 0, 0, 0, 0.
- Illegal-command checks:
  - opcode 110 → resp_data = 0, resp_err = 1.
  - opcode 010 with red_op_A = 1 → resp_err = 1.
  - opcode 110 with bypass_A = 1 → resp_err = 0.
- resp_ready held low for 5 cycles → resp_valid and resp_data stable, req_ready = 00, busy = 1; release → IDLE the next cycle.
- rst = 0 during ISSUE → next cycle: busy = 0, resp_valid = 00, ALSU pins at parking, no response ever delivered; after release req0 wins first.
